dpd_lut_addr_gen: RTL and testbench

Front-end stage of the DPD actuator. It computes instantaneous power |x|^2 = I^2 + Q^2 of each incoming IQ sample and scales it by a runtime gain shift. The result is saturated into a LUT address that drives the LUT read port directly. It also delays the IQ sample so it leaves aligned with the LUT word, which the LUT presents one cycle after the address, for the downstream complex multiplier. A saturating counter records how often the address clipped.

---
 rtl/dpd_lut_addr_gen.sv | 131 +++++++++++++
 tb/tb_dpd_lut_addr_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dpd_lut_addr_gen.sv
// DPD actuator front end: computes |x|^2 of each IQ sample, applies a gain shift and saturates
// the result into a LUT address. The IQ sample is delayed so it leaves aligned with the LUT word.
module dpd_lut_addr_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  input  logic        [3:0]            cfg_shift,
  input  logic                         sat_clear,
  output logic        [ADDR_WIDTH-1:0] lut_addr,
  output logic                         lut_addr_valid,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q,
  output logic        [CNT_WIDTH-1:0]  sat_count
);

  localparam int PW = 2 * DATA_WIDTH;  // full-precision power width
  localparam int SW = PW + 15;         // power after the largest possible shift

  // Stage 1: squares
  logic                         v1;
  logic        [PW-1:0]         sq_i, sq_q;
  logic signed [DATA_WIDTH-1:0] d1_i, d1_q;
  // Stage 2: power
  logic                         v2;
  logic        [PW-1:0]         pwr;
  logic signed [DATA_WIDTH-1:0] d2_i, d2_q;
  // Stage 3: IQ held alongside the address
  logic signed [DATA_WIDTH-1:0] d3_i, d3_q;

  logic signed [PW-1:0]         ext_i, ext_q;
  logic        [SW-1:0]         shifted;
  logic                         overflow;
  logic        [ADDR_WIDTH-1:0] addr_next;

  assign ext_i = PW'(in_i);
  assign ext_q = PW'(in_q);

  assign shifted  = {15'b0, pwr} << cfg_shift;
  assign overflow = (shifted >> PW) != '0;

  // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    addr_next = ADDR_WIDTH'(shifted >> (PW - ADDR_WIDTH));
    if (overflow) addr_next = '1;
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      lut_addr_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
      lut_addr_valid <= v2;
      out_valid <= lut_addr_valid;
    end
  end

  // NOTE: data registers are reset too, so outputs read 0 after reset rather than stale samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_i <= '0;
      sq_q <= '0;
      d1_i <= '0;
      d1_q <= '0;
    end else if (in_valid) begin
      sq_i <= $unsigned(ext_i * ext_i);
      sq_q <= $unsigned(ext_q * ext_q);
      d1_i <= in_i;
      d1_q <= in_q;
    end
  end

  // The sum cannot overflow: the largest power is 2^(PW-1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwr  <= '0;
      d2_i <= '0;
      d2_q <= '0;
    end else if (v1) begin
      pwr  <= sq_i + sq_q;
      d2_i <= d1_i;
      d2_q <= d1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_addr <= '0;
      d3_i     <= '0;
      d3_q     <= '0;
    end else if (v2) begin
      lut_addr <= addr_next;
      d3_i     <= d2_i;
      d3_q     <= d2_q;
    end
  end

  // Final IQ stage lines the sample up with the LUT's registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_i <= '0;
      out_q <= '0;
    end else if (lut_addr_valid) begin
      out_i <= d3_i;
      out_q <= d3_q;
    end
  end

  // A clear wins over a coincident clip event, which is then lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (v2 && overflow && !(&sat_count)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dpd_lut_addr_gen.sv
// Scoreboard bench for dpd_lut_addr_gen: stimulus pushes expected addresses and IQ words,
// a negedge monitor pops and compares them whenever the DUT flags valid output.
module tb_dpd_lut_addr_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] in_i, in_q;
  logic        [3:0]  cfg_shift;
  logic               sat_clear;
  logic        [9:0]  lut_addr;
  logic               lut_addr_valid;
  logic               out_valid;
  logic signed [15:0] out_i, out_q;
  logic        [15:0] sat_count;

  int n_total = 0;
  int n_bad   = 0;

  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_out_q[$];
  logic [9:0]  last_addr = '0;
  logic [31:0] last_out  = '0;

  dpd_lut_addr_gen #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .cfg_shift(cfg_shift), .sat_clear(sat_clear), .lut_addr(lut_addr),
    .lut_addr_valid(lut_addr_valid), .out_valid(out_valid), .out_i(out_i),
    .out_q(out_q), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on valid outputs, otherwise checks that the data holds.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (lut_addr_valid) begin
        if (exp_addr_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_addr: got %0d with nothing expected", lut_addr);
        end else begin
          last_addr = exp_addr_q.pop_front();
          check("lut_addr", 32'(lut_addr), 32'(last_addr));
        end
      end else begin
        check("addr_hold", 32'(lut_addr), 32'(last_addr));
      end
      if (out_valid) begin
        if (exp_out_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_out: got i=0x%0h q=0x%0h with nothing expected", out_i, out_q);
        end else begin
          last_out = exp_out_q.pop_front();
          check("out_iq", {out_i, out_q}, last_out);
        end
      end else begin
        check("out_hold", {out_i, out_q}, last_out);
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] q);
    @(posedge clk);
    #1;
    in_valid = v;
    in_i     = i;
    in_q     = q;
  endtask

  task automatic issue(input logic [15:0] i, input logic [15:0] q, input logic [9:0] exp_addr);
    exp_addr_q.push_back(exp_addr);
    exp_out_q.push_back({i, q});
    drive(1'b1, i, q);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 16'h0, 16'h0);
  endtask

  task automatic run_one(input logic [15:0] i, input logic [15:0] q, input logic [3:0] sh,
                         input logic [9:0] exp_addr);
    cfg_shift = sh;
    issue(i, q, exp_addr);
    idle(6);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (exp_addr_q.size() != 0 || exp_out_q.size() != 0); k++)
      @(negedge clk);
    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out_q.size()), 32'd0);
  endtask

  // Ramp on I with Q=0: address = (k*1024)^2 >> 22 = k^2/4 truncated.
  logic [9:0] ramp_addr[8] = '{10'd0, 10'd1, 10'd2, 10'd4, 10'd6, 10'd9, 10'd12, 10'd16};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_i = '0; in_q = '0; cfg_shift = '0; sat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_addr_valid", 32'(lut_addr_valid), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sat_count", 32'(sat_count), 32'd0);

    // Latency: address on cycle 3, IQ on cycle 4.
    cfg_shift = 4'd0;
    issue(16'h4000, 16'h0000, 10'd64);
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk); check("lat_addr_c1", 32'(lut_addr_valid), 32'd0);
    @(negedge clk); check("lat_addr_c2", 32'(lut_addr_valid), 32'd0);
    @(negedge clk); check("lat_addr_c3", 32'(lut_addr_valid), 32'd1);
    check("lat_out_c3", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_out_c4", 32'(out_valid), 32'd1);
    check("lat_addr_c4", 32'(lut_addr_valid), 32'd0);
    check("sat_after_first", 32'(sat_count), 32'd0);
    idle(3);

    // p = 1638400: truncation and shift scaling.
    run_one(16'h0400, 16'h0300, 4'd0, 10'd0);
    run_one(16'h0400, 16'h0300, 4'd4, 10'd6);
    run_one(16'h4000, 16'h0000, 4'd2, 10'd256);

    // Most negative on both components.
    run_one(16'h8000, 16'h8000, 4'd0, 10'd512);
    check("sat_no_clip", 32'(sat_count), 32'd0);
    run_one(16'h8000, 16'h8000, 4'd1, 10'd1023);
    check("sat_first_clip", 32'(sat_count), 32'd1);

    // 65535 further clips at full rate: counter must stick at all ones.
    for (int k = 0; k < 65535; k++) issue(16'h8000, 16'h8000, 10'd1023);
    idle(6);
    check("sat_saturated", 32'(sat_count), 32'd65535);
    drain();

    // Ramp with bubbles after the 2nd and 5th samples.
    cfg_shift = 4'd0;
    for (int k = 0; k < 8; k++) begin
      issue(16'((k + 1) * 16'h0400), 16'h0000, ramp_addr[k]);
      if (k == 1 || k == 4) idle(k == 1 ? 1 : 2);
    end
    idle(6);
    drain();

    // Mid-stream reset with three samples in flight: none may emerge.
    drive(1'b1, 16'h1111, 16'h2222);
    drive(1'b1, 16'h3333, 16'h4444);
    drive(1'b1, 16'h5555, 16'h6666);
    rst_n = 1'b0;
    last_addr = '0;
    last_out  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(lut_addr), 32'd0);
    check("rst_addr_valid", 32'(lut_addr_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_iq", {out_i, out_q}, 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    idle(6);

    // Clear coinciding with an overflowing stage-3 load.
    run_one(16'h8000, 16'h8000, 4'd3, 10'd1023);
    check("sat_before_clear", 32'(sat_count), 32'd1);
    issue(16'h8000, 16'h8000, 10'd1023);
    drive(1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1 sat_clear = 1'b1;
    @(posedge clk);
    #1 sat_clear = 1'b0;
    @(negedge clk);
    check("sat_clear_priority", 32'(sat_count), 32'd0);
    idle(4);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
